// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator definitions: layer indices and the layer sequencer
// state encoding.
package lenet_pkg;

    localparam int LYR_CONV1  = 0;
    localparam int LYR_POOL1  = 1;
    localparam int LYR_CONV2  = 2;
    localparam int LYR_POOL2  = 3;
    localparam int LYR_FC     = 4;
    localparam int NUM_LAYERS = 5;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_SCAN   = 6'b000010,
        S_LAUNCH = 6'b000100,
        S_RUN    = 6'b001000,
        S_FINISH = 6'b010000,
        S_ERR    = 6'b100000
    } seq_state_t;

endpackage

// File: rtl/dram_port_mux.sv
// Routes the selected engine's DRAM request port onto the shared DRAM
// interface.
// When the mux is inactive, every output is 0.
module dram_port_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_LAYERS = 5,
    parameter int SEL_WIDTH  = 3
) (
    input  logic [SEL_WIDTH-1:0]             sel,
    input  logic                             active,
    input  logic                             dram_valid,
    input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] lyr_addr_in,
    input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] lyr_addr_out,
    input  logic [NUM_LAYERS*DATA_WIDTH-1:0] lyr_data_out,
    input  logic [NUM_LAYERS-1:0]            lyr_en_rd,
    input  logic [NUM_LAYERS-1:0]            lyr_en_wr,
    output logic [NUM_LAYERS-1:0]            lyr_dram_valid,
    output logic [ADDR_WIDTH-1:0]            dram_addr_rd,
    output logic [ADDR_WIDTH-1:0]            dram_addr_wr,
    output logic [DATA_WIDTH-1:0]            dram_data_wr,
    output logic                             dram_en_rd,
    output logic                             dram_en_wr
);

    // NOTE: every output gets a default before the selection loop so no
    // path through the block leaves one unassigned (which would infer a latch).
    always_comb begin
        lyr_dram_valid = '0;
        dram_addr_rd   = '0;
        dram_addr_wr   = '0;
        dram_data_wr   = '0;
        dram_en_rd     = 1'b0;
        dram_en_wr     = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (active && sel == SEL_WIDTH'(i)) begin
                lyr_dram_valid[i] = dram_valid;
                dram_addr_rd      = lyr_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                dram_addr_wr      = lyr_addr_out[i*ADDR_WIDTH +: ADDR_WIDTH];
                dram_data_wr      = lyr_data_out[i*DATA_WIDTH +: DATA_WIDTH];
                dram_en_rd        = lyr_en_rd[i];
                dram_en_wr        = lyr_en_wr[i];
            end
        end
    end

endmodule

// File: rtl/layer_seq.sv
// LeNet layer sequencer: launches the selected engines one at a time in index
// order, shares the DRAM port with the active engine, and runs a per-layer watchdog.
module layer_seq #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 18,
    parameter int          NUM_LAYERS = lenet_pkg::NUM_LAYERS,
    parameter int unsigned TIMEOUT    = 262143
) (
    input  logic                             clk,
    input  logic                             srstn,
    input  logic                             start,
    input  logic [NUM_LAYERS-1:0]            layer_mask,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [2:0]                       err_layer,
    output logic [31:0]                      run_cycles,
    output logic [NUM_LAYERS-1:0]            lyr_enable,
    input  logic [NUM_LAYERS-1:0]            lyr_done,
    output logic [NUM_LAYERS-1:0]            lyr_dram_valid,
    input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] lyr_addr_in,
    input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] lyr_addr_out,
    input  logic [NUM_LAYERS*DATA_WIDTH-1:0] lyr_data_out,
    input  logic [NUM_LAYERS-1:0]            lyr_en_rd,
    input  logic [NUM_LAYERS-1:0]            lyr_en_wr,
    input  logic                             dram_valid,
    output logic [ADDR_WIDTH-1:0]            dram_addr_rd,
    output logic [ADDR_WIDTH-1:0]            dram_addr_wr,
    output logic [DATA_WIDTH-1:0]            dram_data_wr,
    output logic                             dram_en_rd,
    output logic                             dram_en_wr
);

    import lenet_pkg::*;

    localparam logic [2:0] LAST = 3'(NUM_LAYERS - 1);

    seq_state_t            state, state_nx;
    logic [2:0]            cur;
    logic [NUM_LAYERS-1:0] mask;
    logic [31:0]           wdog;
    logic                  mux_active;
    logic                  wdog_expired;

    assign wdog_expired = (wdog == TIMEOUT);

    // NOTE: reset is sampled on the clock edge only; srstn is not in the
    // sensitivity list.
    always_ff @(posedge clk) begin
        if (!srstn) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_ERR: if (start) state_nx = S_SCAN;
            S_SCAN: begin
                if (mask[cur])         state_nx = S_LAUNCH;
                else if (cur == LAST)  state_nx = S_FINISH;
            end
            S_LAUNCH: state_nx = S_RUN;
            S_RUN: begin
                if (lyr_done[cur])     state_nx = (cur == LAST) ? S_FINISH : S_SCAN;
                else if (wdog_expired) state_nx = S_ERR;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_FINISH);
        mux_active = (state == S_LAUNCH) || (state == S_RUN);
        lyr_enable = '0;
        if (state == S_LAUNCH) lyr_enable = NUM_LAYERS'(1) << cur;
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // register updates from the values it held before the edge.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            cur        <= '0;
            mask       <= '0;
            wdog       <= '0;
            error      <= 1'b0;
            err_layer  <= '0;
            run_cycles <= '0;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        mask       <= layer_mask;
                        cur        <= '0;
                        error      <= 1'b0;
                        run_cycles <= '0;
                    end
                end
                S_SCAN:   if (!mask[cur] && cur != LAST) cur <= cur + 3'd1;
                S_LAUNCH: wdog <= '0;
                S_RUN: begin
                    if (lyr_done[cur]) begin
                        if (cur != LAST) cur <= cur + 3'd1;
                    end else if (wdog_expired) begin
                        error     <= 1'b1;
                        err_layer <= cur;
                    end else begin
                        wdog <= wdog + 32'd1;
                    end
                end
                default: ;
            endcase
            // Counts the run itself; holds once the run ends or the watchdog fires.
            if (state != S_IDLE && state != S_ERR && run_cycles != '1)
                run_cycles <= run_cycles + 32'd1;
        end
    end

    dram_port_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_LAYERS (NUM_LAYERS),
        .SEL_WIDTH  (3)
    ) u_mux (
        .sel            (cur),
        .active         (mux_active),
        .dram_valid     (dram_valid),
        .lyr_addr_in    (lyr_addr_in),
        .lyr_addr_out   (lyr_addr_out),
        .lyr_data_out   (lyr_data_out),
        .lyr_en_rd      (lyr_en_rd),
        .lyr_en_wr      (lyr_en_wr),
        .lyr_dram_valid (lyr_dram_valid),
        .dram_addr_rd   (dram_addr_rd),
        .dram_addr_wr   (dram_addr_wr),
        .dram_data_wr   (dram_data_wr),
        .dram_en_rd     (dram_en_rd),
        .dram_en_wr     (dram_en_wr)
    );

endmodule

// File: tb/tb_layer_seq.sv
// Randomized scoreboard bench for layer_seq: a timeline model predicts enable/done/error
// events and the per-cycle DRAM owner; a monitor compares against the DUT.
module tb_layer_seq;

    localparam int NL  = 5;
    localparam int AW  = 18;
    localparam int DW  = 32;
    localparam int TMO = 100;

    typedef enum int {EV_EN, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       idx;
        int       cyc;
        int       rc;
    } ev_t;

    logic              clk, srstn, start, busy, done, error, dram_valid;
    logic              dram_en_rd, dram_en_wr;
    logic [2:0]        err_layer;
    logic [31:0]       run_cycles;
    logic [NL-1:0]     layer_mask, lyr_enable, lyr_done, lyr_dram_valid, lyr_en_rd, lyr_en_wr;
    logic [NL*AW-1:0]  lyr_addr_in, lyr_addr_out;
    logic [NL*DW-1:0]  lyr_data_out;
    logic [AW-1:0]     dram_addr_rd, dram_addr_wr;
    logic [DW-1:0]     dram_data_wr;

    layer_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LAYERS(NL), .TIMEOUT(TMO)) dut (
        .clk(clk), .srstn(srstn), .start(start), .layer_mask(layer_mask),
        .busy(busy), .done(done), .error(error), .err_layer(err_layer),
        .run_cycles(run_cycles), .lyr_enable(lyr_enable), .lyr_done(lyr_done),
        .lyr_dram_valid(lyr_dram_valid), .lyr_addr_in(lyr_addr_in),
        .lyr_addr_out(lyr_addr_out), .lyr_data_out(lyr_data_out),
        .lyr_en_rd(lyr_en_rd), .lyr_en_wr(lyr_en_wr), .dram_valid(dram_valid),
        .dram_addr_rd(dram_addr_rd), .dram_addr_wr(dram_addr_wr),
        .dram_data_wr(dram_data_wr), .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr)
    );

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_on = 0;
    bit   fix2 = 0;
    int   lat[NL];
    int   due[NL];
    int   spur_cyc = -1;
    int   spur_idx = 4;
    ev_t  sb_q[$];
    int   sel_at[int];
    bit   busy_at[int];
    bit   err_at[int];
    bit   dflt_busy = 0;
    bit   dflt_err = 0;
    bit   pend_rc_v = 0;
    int   pend_rc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Timeline model: walks the layers with the documented cycle costs.
    task automatic model_run(input int s, input logic [NL-1:0] m, output int end_c);
        int t, e, d, last;
        busy_at[s] = dflt_busy;
        err_at[s]  = dflt_err;
        t = s + 1;
        for (int i = 0; i < NL; i++) begin
            if (m[i]) begin
                e = t + 1;
                sb_q.push_back('{EV_EN, i, e, 0});
                if (lat[i] == 0) begin
                    last = e + 1 + TMO;
                    for (int c = e; c <= last; c++) sel_at[c] = i;
                    for (int c = s + 1; c <= last; c++) begin
                        busy_at[c] = 1'b1;
                        err_at[c]  = 1'b0;
                    end
                    sb_q.push_back('{EV_ERR, i, last + 1, last - s});
                    dflt_busy = 1'b1;
                    dflt_err  = 1'b1;
                    end_c     = last + 1;
                    return;
                end
                d = e + lat[i];
                for (int c = e; c <= d; c++) sel_at[c] = i;
                t = d + 1;
            end else begin
                t = t + 1;
            end
        end
        sb_q.push_back('{EV_DONE, 0, t, t - s});
        for (int c = s + 1; c <= t; c++) begin
            busy_at[c] = 1'b1;
            err_at[c]  = 1'b0;
        end
        dflt_busy = 1'b0;
        dflt_err  = 1'b0;
        end_c     = t;
    endtask

    task automatic trunc_after(input int p);
        int keys[$];
        foreach (sel_at[k])  if (k > p) keys.push_back(k);
        foreach (keys[j])    sel_at.delete(keys[j]);
        keys.delete();
        foreach (busy_at[k]) if (k > p) keys.push_back(k);
        foreach (keys[j])    begin busy_at.delete(keys[j]); err_at.delete(keys[j]); end
        dflt_busy = 1'b0;
        dflt_err  = 1'b0;
        sb_q.delete();
        pend_rc_v = 1'b0;
    endtask

    // Random traffic on every engine port; engine 2 can be pinned to a known request.
    initial begin
        lyr_addr_in = '0; lyr_addr_out = '0; lyr_data_out = '0;
        lyr_en_rd = '0; lyr_en_wr = '0; dram_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NL; i++) begin
                lyr_addr_in[i*AW +: AW]  = AW'($urandom);
                lyr_addr_out[i*AW +: AW] = AW'($urandom);
                lyr_data_out[i*DW +: DW] = $urandom;
            end
            lyr_en_rd  = NL'($urandom);
            lyr_en_wr  = NL'($urandom);
            dram_valid = 1'($urandom);
            if (fix2) begin
                lyr_en_rd[2]          = 1'b1;
                lyr_addr_in[2*AW +: AW] = 18'h10000;
            end
        end
    end

    // Engine models: done pulses lat[i] cycles after the enable; lat 0 never finishes.
    initial begin
        for (int i = 0; i < NL; i++) due[i] = -1;
        lyr_done = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                if (!srstn)             due[i] = -1;
                else if (lyr_enable[i]) due[i] = (lat[i] == 0) ? -1 : cyc + lat[i];
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NL; i++)
                lyr_done[i] = (due[i] == cyc) || (i == spur_idx && cyc == spur_cyc);
        end
    end

    // NOTE: outputs are sampled on the falling edge, half a period away from
    // the edge where inputs and state change.
    initial begin : monitor
        int            c, s;
        bit            prev_err;
        ev_t           ev;
        logic [NL-1:0] vld;
        logic [127:0]  act, exp;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                c   = cyc;
                s   = sel_at.exists(c) ? sel_at[c] : -1;
                exp = '0;
                if (s >= 0) begin
                    vld = '0;
                    vld[s] = dram_valid;
                    exp = {lyr_en_rd[s], lyr_en_wr[s], lyr_addr_in[s*AW +: AW],
                           lyr_addr_out[s*AW +: AW], lyr_data_out[s*DW +: DW], vld};
                end
                act = {dram_en_rd, dram_en_wr, dram_addr_rd, dram_addr_wr, dram_data_wr, lyr_dram_valid};
                check("dram_mux", act, exp);
                check("busy", busy, busy_at.exists(c) ? busy_at[c] : dflt_busy);
                check("error", error, err_at.exists(c) ? err_at[c] : dflt_err);
                if (pend_rc_v) begin
                    check("run_cycles", run_cycles, pend_rc);
                    pend_rc_v = 1'b0;
                end
                if (lyr_enable != '0 || done || (error && !prev_err)) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_event at cycle %0d: got enable=%0h done=%0b error=%0b, expected none",
                                 c, lyr_enable, done, error);
                    end else begin
                        ev = sb_q.pop_front();
                        check("event_cycle", c, ev.cyc);
                        case (ev.kind)
                            EV_EN:   check("enable_vec", lyr_enable, NL'(1) << ev.idx);
                            EV_DONE: begin
                                check("done_pulse", {lyr_enable, done}, {NL'(0), 1'b1});
                                pend_rc   = ev.rc;
                                pend_rc_v = 1'b1;
                            end
                            default: begin
                                check("err_layer", err_layer, ev.idx);
                                check("err_run_cycles", run_cycles, ev.rc);
                            end
                        endcase
                    end
                end
                prev_err = error;
            end
        end
    end

    task automatic do_run(input logic [NL-1:0] m, input int spur_rel, input int busy_start_rel);
        int s, end_c;
        @(posedge clk);
        #1;
        start      = 1'b1;
        layer_mask = m;
        s          = cyc;
        model_run(s, m, end_c);
        spur_cyc   = (spur_rel > 0) ? s + spur_rel : -1;
        while (cyc < end_c + 2) begin
            @(posedge clk);
            #1;
            start      = (busy_start_rel > 0 && cyc == s + busy_start_rel);
            layer_mask = NL'($urandom);
        end
        spur_cyc = -1;
        check("queue_empty", sb_q.size(), 0);
    endtask

    task automatic rand_lat(input int lo, input int hi);
        for (int i = 0; i < NL; i++) lat[i] = $urandom_range(hi, lo);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1);
    end

    initial begin : main
        int s, p, end_c;
        srstn = 1'b0; start = 1'b0; layer_mask = '0;
        for (int i = 0; i < NL; i++) lat[i] = 10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {busy, done, error, err_layer, run_cycles, lyr_enable},
              {1'b0, 1'b0, 1'b0, 3'd0, 32'd0, NL'(0)});
        check("rst_dram", {dram_en_rd, dram_en_wr, dram_addr_rd, dram_addr_wr, dram_data_wr, lyr_dram_valid}, '0);
        mon_on = 1'b1;
        @(posedge clk);
        #1;
        srstn = 1'b1;

        do_run(5'b11111, 0, 0);                 // every layer, 10-cycle engines
        rand_lat(1, 30);
        do_run(5'b10010, 0, 0);                 // skipped layers
        do_run(5'b00000, 0, 0);                 // empty mask
        fix2 = 1'b1;
        lat[2] = 20;
        do_run(5'b00101, 0, 0);                 // engine 2 owns the DRAM port
        fix2 = 1'b0;

        rand_lat(1, 40);
        lat[3] = 0;
        do_run(5'b11111, 0, 0);                 // watchdog on layer 3
        repeat (5) @(posedge clk);
        rand_lat(1, 40);
        do_run(5'(($urandom % 32) | 1), 0, 0);  // restart from ERR

        for (int i = 0; i < NL; i++) lat[i] = 10;
        do_run(5'b11111, 18, 20);               // spurious done[4] and start while busy

        // Reset pulse in the middle of layer 2.
        @(posedge clk);
        #1;
        start = 1'b1; layer_mask = 5'b11111; s = cyc;
        model_run(s, 5'b11111, end_c);
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc < s + 30) @(posedge clk);
        #1;
        srstn = 1'b0;
        p = cyc;
        trunc_after(p);
        @(posedge clk);
        #1;
        srstn = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {done, err_layer, run_cycles, lyr_enable},
              {1'b0, 3'd0, 32'd0, NL'(0)});
        repeat (2) @(posedge clk);
        do_run(5'b11111, 0, 0);

        for (int r = 0; r < 10; r++) begin
            rand_lat(1, 40);
            do_run(NL'($urandom), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
